// File: rtl/yolo_sched_pkg.sv
// yolo_sched_pkg
// Shared types and constants for the YOLO frame scheduler.
//   sched_state_t : scheduler FSM states (IDLE between frames, STREAM while
//                   a granted source owns the accelerator input)
//   pixel_t       : one 24-bit RGB pixel
//   YOLO_*        : native 416x416 frame geometry and the detection count
//                   (13x13 grid, 2 anchors) that retires one frame
//   cnt_w()       : counter width for a terminal count n, never below 1 bit
package yolo_sched_pkg;

  typedef enum logic {IDLE, STREAM} sched_state_t;

  typedef logic [23:0] pixel_t;

  localparam int YOLO_W    = 416;
  localparam int YOLO_H    = 416;
  localparam int YOLO_DETS = 338;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yolo_sched_id_fifo.sv
// yolo_sched_id_fifo
// Small synchronous FIFO that remembers which source (0/1) each in-flight
// frame came from, so retirements can be attributed in grant order.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write din_i (ignored when full and not popping)
//   pop_i     : drop the head entry (ignored when empty)
//   flush_i   : discard every entry; wins over push/pop
//   din_i     : source id to store
//   dout_o    : source id at the head (valid while !empty_o)
//   empty_o   : no entries stored
//   full_o    : DEPTH entries stored
module yolo_sched_id_fifo
  import yolo_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic din_i,
  output logic dout_o,
  output logic empty_o,
  output logic full_o
);

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; a flush empties the FIFO outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= inc_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= inc_ptr(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/yolo_frame_sched.sv
// yolo_frame_sched
// Frame-level round-robin scheduler feeding one FINN/YOLO accelerator stream
// from two RGB pixel sources. A source owns the output for a whole frame;
// frames are retired by counting yolo_post detections, and the number of
// frames in flight is capped.
// Optional feature: define YOLO_SCHED_TIMEOUT_EN to build the watchdog that
// flushes in-flight bookkeeping when detections stop arriving.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   s0_* / s1_*         : AXI-stream pixel sources (tdata/tvalid/tready)
//   m_tdata/m_tvalid/
//   m_tready            : stream towards the accelerator
//   det_valid           : one detection per high cycle
//   frame_done          : one-cycle pulse when the oldest frame retires
//   frame_done_src      : source id of that frame, valid with frame_done
//   inflight            : frames forwarded but not yet retired
//   det_orphan_err      : sticky, detection seen with nothing in flight
//   timeout_err         : sticky watchdog flag (0 without the watchdog)
module yolo_frame_sched
  import yolo_sched_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = YOLO_W * YOLO_H,
  parameter int DETS_PER_FRAME   = YOLO_DETS,
  parameter int MAX_INFLIGHT     = 2,
  parameter int TIMEOUT_CYCLES   = 2000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  pixel_t                            s0_tdata,
  input  logic                              s0_tvalid,
  output logic                              s0_tready,
  input  pixel_t                            s1_tdata,
  input  logic                              s1_tvalid,
  output logic                              s1_tready,
  output pixel_t                            m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  input  logic                              det_valid,
  output logic                              frame_done,
  output logic                              frame_done_src,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              det_orphan_err,
  output logic                              timeout_err
);

  localparam int PIX_W = cnt_w(PIXELS_PER_FRAME);
  localparam int DET_W = cnt_w(DETS_PER_FRAME);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  sched_state_t     state_q;
  logic             sel_q, rr_q;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [DET_W-1:0] det_cnt_q, det_cnt_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             done_q, done_src_q, orphan_q;

  logic streaming, sel_valid, beat, last_beat;
  logic grant, grant_src, det_live, retire, orphan_hit, wd_fire;
  logic fifo_dout, fifo_empty, fifo_full;

  // Arbitration happens only in IDLE; when both sources ask, rr_q breaks the tie.
  assign grant     = (state_q == IDLE) && (inflight_q != INF_W'(MAX_INFLIGHT)) &&
                     !fifo_full && (s0_tvalid || s1_tvalid);
  assign grant_src = (s0_tvalid && s1_tvalid) ? rr_q : s1_tvalid;

  assign streaming = (state_q == STREAM);
  assign sel_valid = sel_q ? s1_tvalid : s0_tvalid;
  assign beat      = streaming && sel_valid && m_tready;
  assign last_beat = beat && (pix_cnt_q == PIX_W'(PIXELS_PER_FRAME - 1));

  assign det_live   = det_valid && (inflight_q != '0);
  assign retire     = det_live && (det_cnt_q == DET_W'(DETS_PER_FRAME - 1)) && !fifo_empty;
  assign orphan_hit = det_valid && (inflight_q == '0);

  // Zero-latency pass-through of the owning source; everything is quiet in IDLE.
  assign m_tdata   = streaming ? (sel_q ? s1_tdata : s0_tdata) : '0;
  assign m_tvalid  = streaming && sel_valid;
  assign s0_tready = streaming && !sel_q && m_tready;
  assign s1_tready = streaming &&  sel_q && m_tready;

  assign frame_done     = done_q;
  assign frame_done_src = done_src_q;
  assign inflight       = inflight_q;
  assign det_orphan_err = orphan_q;

  yolo_sched_id_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .pop_i   (retire),
    .flush_i (wd_fire),
    .din_i   (grant_src),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Frame FSM: a grant takes one IDLE cycle, after which the chosen source
  // keeps the output until its last pixel, even across tvalid gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rr_q      <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            sel_q     <= grant_src;
            rr_q      <= ~grant_src;
            pix_cnt_q <= '0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (last_beat) begin
            pix_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (beat) begin
            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next values for the detection counter and in-flight count. A grant and a
  // retirement in the same cycle cancel out; a watchdog flush clears both and
  // drops any grant made in that cycle.
  always_comb begin
    inflight_d = inflight_q;
    det_cnt_d  = det_cnt_q;
    if (wd_fire) begin
      inflight_d = '0;
      det_cnt_d  = '0;
    end else begin
      if (det_live) begin
        det_cnt_d = retire ? '0 : det_cnt_q + DET_W'(1);
      end
      if (grant && !retire) begin
        inflight_d = inflight_q + INF_W'(1);
      end else if (!grant && retire) begin
        inflight_d = inflight_q - INF_W'(1);
      end
    end
  end

  // Retirement bookkeeping; frame_done and its source id are registered so
  // they appear the cycle after the final detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      det_cnt_q  <= '0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      det_cnt_q  <= det_cnt_d;
      done_q     <= retire;
      done_src_q <= retire ? fifo_dout : 1'b0;
      orphan_q   <= orphan_q | orphan_hit;
    end
  end

`ifdef YOLO_SCHED_TIMEOUT_EN
  localparam int WD_W = cnt_w(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // Fires when frames are outstanding but no detection has arrived for
  // TIMEOUT_CYCLES cycles; a detection on that same cycle wins.
  assign wd_fire     = (inflight_q != '0) && !det_valid &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  // Watchdog counter: runs only while something is in flight and restarts
  // on every detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((inflight_q == '0) || det_valid || wd_fire) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
      timeout_q <= timeout_q | wd_fire;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_yolo_frame_sched.sv
// tb_yolo_frame_sched
// Directed bench for yolo_frame_sched with 16-pixel frames, 4 detections per
// frame, 2 frames in flight and a 64-cycle watchdog. Source 0 pixels carry
// tag 0x00 in bits 23:16 and source 1 pixels tag 0x11, with the per-source
// pixel index in bits 7:0, so every forwarded beat identifies its origin.
module tb_yolo_frame_sched;

  localparam int PIX = 16;
  localparam int DETS = 4;
  localparam int MAXF = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tready, s1_tready;
  logic        m_tvalid, m_tready = 1'b0;
  logic        det_valid = 1'b0;
  logic        frame_done, frame_done_src, det_orphan_err, timeout_err;
  logic [1:0]  inflight;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int s0Left = 0, s1Left = 0, s0Idx = 0, s1Idx = 0;
  int gapPct = 0, rdyPct = 100;
  bit fire0, fire1;

  logic [23:0] beatQ[$];
  int          beatCyc[$];
  logic        doneQ[$];

  yolo_frame_sched #(
    .PIXELS_PER_FRAME (PIX),
    .DETS_PER_FRAME   (DETS),
    .MAX_INFLIGHT     (MAXF),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_tdata       (s0_tdata),
    .s0_tvalid      (s0_tvalid),
    .s0_tready      (s0_tready),
    .s1_tdata       (s1_tdata),
    .s1_tvalid      (s1_tvalid),
    .s1_tready      (s1_tready),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .det_valid      (det_valid),
    .frame_done     (frame_done),
    .frame_done_src (frame_done_src),
    .inflight       (inflight),
    .det_orphan_err (det_orphan_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every accepted output beat and every frame_done pulse mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beatQ.push_back(m_tdata);
      beatCyc.push_back(cyc);
    end
    if (frame_done) doneQ.push_back(frame_done_src);
  end

  // Source and sink model: each source offers s*Left more pixels, optionally
  // with random valid gaps; the accelerator accepts with probability rdyPct.
  initial begin
    forever begin
      @(negedge clk);
      fire0 = s0_tvalid && s0_tready;
      fire1 = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (fire0) begin s0Idx++; s0Left--; end
      if (fire1) begin s1Idx++; s1Left--; end
      s0_tvalid = (s0Left > 0) && ($urandom_range(0, 99) >= gapPct);
      s1_tvalid = (s1Left > 0) && ($urandom_range(0, 99) >= gapPct);
      s0_tdata  = {8'h00, 8'h00, s0Idx[7:0]};
      s1_tdata  = {8'h11, 8'h00, s1Idx[7:0]};
      m_tready  = ($urandom_range(0, 99) < rdyPct);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    det_valid = 1'b0;
    s0Left = 0; s1Left = 0;
    gapPct = 0; rdyPct = 100;
    repeat (3) tick();
    s0Idx = 0; s1Idx = 0;
    beatQ.delete(); beatCyc.delete(); doneQ.delete();
    rst = 1'b0;
  endtask

  task automatic send_dets(input int n);
    det_valid = 1'b1;
    repeat (n) tick();
    det_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int i = 0;
    while (beatQ.size() < n && i < budget) begin
      tick();
      i++;
    end
    ok = (beatQ.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0Left = 1000; s1Left = 1000; gapPct = 50; rdyPct = 50;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({s0_tready, s1_tready, m_tvalid, frame_done, inflight, det_orphan_err} !== 7'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs[%0d]: got s0r=%b s1r=%b mv=%b fd=%b inf=%0d orph=%b, required all 0",
                 i, s0_tready, s1_tready, m_tvalid, frame_done, inflight, det_orphan_err);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    logic [23:0] exp;
    do_reset();
    s0Left = 2 * PIX;
    wait_beats(2 * PIX, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_beat_count: got %0d beats, required %0d", beatQ.size(), 2 * PIX);
    end else begin
      for (int i = 0; i < 2 * PIX; i++) begin
        exp = 24'(i);
        checks++;
        if (beatQ[i] !== exp) begin
          errors++;
          $display("[TB] FAIL single_data[%0d]: got %h, required %h", i, beatQ[i], exp);
        end
      end
      checks++;
      if (beatCyc[PIX-1] - beatCyc[0] !== PIX - 1) begin
        errors++;
        $display("[TB] FAIL single_no_gaps: span %0d cycles, required %0d", beatCyc[PIX-1] - beatCyc[0], PIX - 1);
      end
      checks++;
      if (beatCyc[PIX] - beatCyc[PIX-1] !== 2) begin
        errors++;
        $display("[TB] FAIL single_bubble: gap %0d cycles, required 2", beatCyc[PIX] - beatCyc[PIX-1]);
      end
    end
    tick();
    checks++;
    if (inflight !== 2'd2) begin
      errors++;
      $display("[TB] FAIL single_inflight2: got %0d, required 2", inflight);
    end
    send_dets(DETS);
    checks++;
    if (doneQ.size() !== 1 || doneQ[0] !== 1'b0 || inflight !== 2'd1) begin
      errors++;
      $display("[TB] FAIL single_retire1: dones=%0d src=%b inflight=%0d, required dones=1 src=0 inflight=1",
               doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : 1'bx, inflight);
    end
    send_dets(DETS);
    checks++;
    if (doneQ.size() !== 2 || doneQ[1] !== 1'b0 || inflight !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_retire2: dones=%0d src=%b inflight=%0d, required dones=2 src=0 inflight=0",
               doneQ.size(), (doneQ.size() > 1) ? doneQ[1] : 1'bx, inflight);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [23:0] exp;
    do_reset();
    s0Left = 3 * PIX; s1Left = 3 * PIX;
    wait_beats(2 * PIX, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL cont_beat_count: got %0d beats, required %0d", beatQ.size(), 2 * PIX);
    end else begin
      for (int i = 0; i < 2 * PIX; i++) begin
        exp = (i < PIX) ? 24'(i) : {8'h11, 8'h00, 8'(i - PIX)};
        checks++;
        if (beatQ[i] !== exp) begin
          errors++;
          $display("[TB] FAIL cont_order[%0d]: got %h, required %h", i, beatQ[i], exp);
        end
      end
    end
    repeat (10) tick();
    checks++;
    if (beatQ.size() !== 2 * PIX || inflight !== 2'd2 || s0_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cont_blocked: beats=%0d inflight=%0d s0_tready=%b, required beats=32 inflight=2 s0_tready=0",
               beatQ.size(), inflight, s0_tready);
    end
    send_dets(DETS);
    checks++;
    if (doneQ.size() !== 1 || doneQ[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cont_retire: dones=%0d src=%b, required dones=1 src=0",
               doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : 1'bx);
    end
    wait_beats(2 * PIX + 1, 50, ok);
    checks++;
    if (!ok || beatQ[2*PIX] !== 24'h000010) begin
      errors++;
      $display("[TB] FAIL cont_regrant: beats=%0d next=%h, required s0 pixel 000010",
               beatQ.size(), ok ? beatQ[2*PIX] : 24'hxxxxxx);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0]  tagA, tagB;
    logic [23:0] exp;
    do_reset();
    gapPct = 30; rdyPct = 50;
    s0Left = PIX; s1Left = PIX;
    wait_beats(2 * PIX, 3000, ok);
    repeat (20) tick();
    checks++;
    if (!ok || beatQ.size() !== 2 * PIX) begin
      errors++;
      $display("[TB] FAIL bp_beat_count: got %0d beats, required %0d", beatQ.size(), 2 * PIX);
    end else begin
      tagA = beatQ[0][23:16];
      tagB = (tagA == 8'h00) ? 8'h11 : 8'h00;
      checks++;
      if (tagA !== 8'h00 && tagA !== 8'h11) begin
        errors++;
        $display("[TB] FAIL bp_first_tag: got %h, required 00 or 11", tagA);
      end
      for (int i = 0; i < 2 * PIX; i++) begin
        exp = {(i < PIX) ? tagA : tagB, 8'h00, 8'(i % PIX)};
        checks++;
        if (beatQ[i] !== exp) begin
          errors++;
          $display("[TB] FAIL bp_frame_data[%0d]: got %h, required %h", i, beatQ[i], exp);
        end
      end
      gapPct = 0; rdyPct = 100;
      send_dets(2 * DETS);
      checks++;
      if (doneQ.size() !== 2 || doneQ[0] !== (tagA == 8'h11) || doneQ[1] !== (tagB == 8'h11)) begin
        errors++;
        $display("[TB] FAIL bp_done_order: dones=%0d srcs=%b,%b, required 2 dones srcs=%b,%b",
                 doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : 1'bx, (doneQ.size() > 1) ? doneQ[1] : 1'bx,
                 tagA == 8'h11, tagB == 8'h11);
      end
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    s0Left = PIX;
    wait_beats(PIX, 100, ok);
    tick();
    det_valid = 1'b1;
    repeat (DETS - 1) tick();
    det_valid = 1'b0;
    tick();
    checks++;
    if (!ok || inflight !== 2'd1 || doneQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL same_pre: beats=%0d inflight=%0d dones=%0d, required 16/1/0",
               beatQ.size(), inflight, doneQ.size());
    end
    s1Left = PIX;
    tick();
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inflight !== 2'd1 || frame_done !== 1'b1 || frame_done_src !== 1'b0 || s1_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_grant_retire: inflight=%0d fd=%b src=%b s1_tready=%b, required 1/1/0/1",
               inflight, frame_done, frame_done_src, s1_tready);
    end
    wait_beats(2 * PIX, 100, ok);
    checks++;
    if (!ok || beatQ[PIX] !== 24'h110000 || beatQ[2*PIX-1] !== 24'h11000F) begin
      errors++;
      $display("[TB] FAIL same_s1_frame: beats=%0d, required 32 ending in s1 pixels 110000..11000F", beatQ.size());
    end
    send_dets(DETS);
    checks++;
    if (doneQ.size() !== 2 || doneQ[1] !== 1'b1 || inflight !== 2'd0) begin
      errors++;
      $display("[TB] FAIL same_fifo_order: dones=%0d src=%b inflight=%0d, required 2/1/0",
               doneQ.size(), (doneQ.size() > 1) ? doneQ[1] : 1'bx, inflight);
    end
  endtask

  task automatic test_errors();
    bit ok;
    do_reset();
    @(negedge clk);
    checks++;
    if (det_orphan_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: orphan=%b timeout=%b, required 0/0", det_orphan_err, timeout_err);
    end
    tick();
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (det_orphan_err !== 1'b1 || inflight !== 2'd0 || doneQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL err_orphan: orphan=%b inflight=%0d dones=%0d, required 1/0/0",
               det_orphan_err, inflight, doneQ.size());
    end
    tick();
    s0Left = PIX;
    wait_beats(PIX, 100, ok);
    repeat (80) tick();
    @(negedge clk);
    checks++;
`ifdef YOLO_SCHED_TIMEOUT_EN
    if (!ok || timeout_err !== 1'b1 || inflight !== 2'd0) begin
      errors++;
      $display("[TB] FAIL err_timeout: timeout=%b inflight=%0d, required 1/0", timeout_err, inflight);
    end
    tick();
    send_dets(DETS);
    checks++;
    if (doneQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL err_flush_no_done: dones=%0d, required 0", doneQ.size());
    end
`else
    if (!ok || timeout_err !== 1'b0 || inflight !== 2'd1) begin
      errors++;
      $display("[TB] FAIL err_no_watchdog: timeout=%b inflight=%0d, required 0/1", timeout_err, inflight);
    end
`endif
  endtask

  initial begin
    $display("[TB] yolo_frame_sched directed tests");
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_same_cycle();
    test_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
